// File: rtl/page_tbl_ctrl.sv
// Page-table RAM sequencer/arbiter: table clear, config write port A, valid/ready lookups on port B.
// Optional statistics counters are enabled by defining PAGE_TBL_CTRL_STATS_EN.
module page_tbl_ctrl #(
  parameter int ADDR_BITS = 5,
  parameter int DATA_BITS = 16,
  parameter int TAG_BITS  = 8,
  parameter logic [DATA_BITS-1:0] INIT_VALUE = '0
) (
  input  logic                 clk,
  input  logic                 aresetn,
  input  logic                 clr_req,
  output logic                 init_done,
  input  logic                 cfg_wr_valid,
  output logic                 cfg_wr_ready,
  input  logic [ADDR_BITS-1:0] cfg_wr_addr,
  input  logic [DATA_BITS-1:0] cfg_wr_data,
  input  logic                 lkup_valid,
  output logic                 lkup_ready,
  input  logic [ADDR_BITS-1:0] lkup_addr,
  input  logic [TAG_BITS-1:0]  lkup_tag,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [DATA_BITS-1:0] rsp_data,
  output logic [TAG_BITS-1:0]  rsp_tag,
  output logic [ADDR_BITS-1:0] ram_addra,
  output logic [DATA_BITS-1:0] ram_dina,
  output logic                 ram_ena,
  output logic                 ram_wea,
  output logic [ADDR_BITS-1:0] ram_addrb,
  output logic                 ram_enb,
  input  logic [DATA_BITS-1:0] ram_doutb,
`ifdef PAGE_TBL_CTRL_STATS_EN
  output logic [31:0]          stat_lkup_cnt,
  output logic [15:0]          stat_fwd_cnt,
`endif
  output logic                 dbg_state
);

  // All handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // valid never depends on ready, and response data holds while rsp_valid is high and rsp_ready low.
  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

  state_t                state_q, state_d;
  logic [ADDR_BITS-1:0]  clr_cnt;
  logic                  clr_pend;
  logic                  inflight;
  logic                  fwd_q;
  logic [DATA_BITS-1:0]  fwd_data;
  logic [TAG_BITS-1:0]   if_tag;
  logic [DATA_BITS-1:0]  buf_data [2];
  logic [TAG_BITS-1:0]   buf_tag  [2];
  logic                  wr_ptr, rd_ptr;
  logic [1:0]            occ;
  logic                  wr_fire, lk_fire, collide, push, pop, enter_init;

  assign dbg_state = state_q;
  assign collide   = wr_fire && lk_fire && (cfg_wr_addr == lkup_addr);
  assign push      = inflight;
  assign rsp_valid = (occ != 2'd0);
  assign pop       = rsp_valid && rsp_ready;
  assign rsp_data  = buf_data[rd_ptr];
  assign rsp_tag   = buf_tag[rd_ptr];

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) state_q <= ST_INIT;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    init_done    = 1'b0;
    cfg_wr_ready = 1'b0;
    lkup_ready   = 1'b0;
    ram_ena      = 1'b0;
    ram_wea      = 1'b0;
    ram_addra    = cfg_wr_addr;
    ram_dina     = cfg_wr_data;
    ram_enb      = 1'b0;
    ram_addrb    = lkup_addr;
    wr_fire      = 1'b0;
    lk_fire      = 1'b0;
    enter_init   = 1'b0;
    case (state_q)
      ST_INIT: begin
        // Gated by aresetn so the RAM sees no write while reset is held.
        ram_ena   = aresetn;
        ram_wea   = aresetn;
        ram_addra = clr_cnt;
        ram_dina  = INIT_VALUE;
        if (&clr_cnt) state_d = ST_RUN;
      end
      ST_RUN: begin
        init_done    = 1'b1;
        cfg_wr_ready = !clr_pend;
        lkup_ready   = !clr_pend && (({1'b0, occ} + {2'b00, inflight}) < 3'd2);
        wr_fire      = cfg_wr_valid && cfg_wr_ready;
        lk_fire      = lkup_valid && lkup_ready;
        ram_ena      = wr_fire;
        ram_wea      = wr_fire;
        ram_enb      = lk_fire;
        if (clr_pend && !inflight && (occ == 2'd0)) begin
          state_d    = ST_INIT;
          enter_init = 1'b1;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      clr_cnt  <= '0;
      clr_pend <= 1'b0;
    end else begin
      clr_cnt <= (state_q == ST_INIT) ? clr_cnt + ADDR_BITS'(1) : '0;
      if (enter_init)                          clr_pend <= 1'b0;
      else if (state_q == ST_RUN && clr_req)   clr_pend <= 1'b1;
    end
  end

  // Read pipeline: a same-cycle colliding write overrides the stale RAM read one cycle later.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      inflight <= 1'b0;
      fwd_q    <= 1'b0;
      fwd_data <= '0;
      if_tag   <= '0;
    end else begin
      inflight <= lk_fire;
      fwd_q    <= collide;
      if (collide) fwd_data <= cfg_wr_data;
      if (lk_fire) if_tag   <= lkup_tag;
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < 2; i++) begin
        buf_data[i] <= '0;
        buf_tag[i]  <= '0;
      end
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      occ    <= 2'd0;
    end else begin
      if (push) begin
        buf_data[wr_ptr] <= fwd_q ? fwd_data : ram_doutb;
        buf_tag[wr_ptr]  <= if_tag;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

`ifdef PAGE_TBL_CTRL_STATS_EN
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      stat_lkup_cnt <= '0;
      stat_fwd_cnt  <= '0;
    end else if (enter_init) begin
      stat_lkup_cnt <= '0;
      stat_fwd_cnt  <= '0;
    end else begin
      if (lk_fire && !(&stat_lkup_cnt)) stat_lkup_cnt <= stat_lkup_cnt + 32'd1;
      if (collide && !(&stat_fwd_cnt))  stat_fwd_cnt  <= stat_fwd_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_page_tbl_ctrl.sv
// Bench for page_tbl_ctrl: RAM model, table-driven lookups with a response scoreboard,
// plus hand sequences for latency, backpressure, clear and mid-flight reset.
module tb_page_tbl_ctrl;
  localparam int AW = 5;
  localparam int DW = 16;
  localparam int TW = 8;

  logic          clk = 1'b0;
  logic          aresetn = 1'b0;
  logic          clr_req = 1'b0;
  logic          init_done;
  logic          cfg_wr_valid = 1'b0;
  logic          cfg_wr_ready;
  logic [AW-1:0] cfg_wr_addr = '0;
  logic [DW-1:0] cfg_wr_data = '0;
  logic          lkup_valid = 1'b0;
  logic          lkup_ready;
  logic [AW-1:0] lkup_addr = '0;
  logic [TW-1:0] lkup_tag = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_data;
  logic [TW-1:0] rsp_tag;
  logic [AW-1:0] ram_addra, ram_addrb;
  logic [DW-1:0] ram_dina;
  logic          ram_ena, ram_wea, ram_enb;
  logic [DW-1:0] ram_doutb;
  logic          dbg_state;
`ifdef PAGE_TBL_CTRL_STATS_EN
  logic [31:0]   stat_lkup_cnt;
  logic [15:0]   stat_fwd_cnt;
`endif

  page_tbl_ctrl dut (
    .clk(clk), .aresetn(aresetn), .clr_req(clr_req), .init_done(init_done),
    .cfg_wr_valid(cfg_wr_valid), .cfg_wr_ready(cfg_wr_ready),
    .cfg_wr_addr(cfg_wr_addr), .cfg_wr_data(cfg_wr_data),
    .lkup_valid(lkup_valid), .lkup_ready(lkup_ready),
    .lkup_addr(lkup_addr), .lkup_tag(lkup_tag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_tag(rsp_tag),
    .ram_addra(ram_addra), .ram_dina(ram_dina), .ram_ena(ram_ena), .ram_wea(ram_wea),
    .ram_addrb(ram_addrb), .ram_enb(ram_enb), .ram_doutb(ram_doutb),
`ifdef PAGE_TBL_CTRL_STATS_EN
    .stat_lkup_cnt(stat_lkup_cnt), .stat_fwd_cnt(stat_fwd_cnt),
`endif
    .dbg_state(dbg_state)
  );

  // Clock/reset block
  always #5 clk = ~clk;

  // Dual-port RAM model: read-before-write, registered read
  logic [DW-1:0] mem [32];
  always @(posedge clk) begin
    if (ram_enb) ram_doutb <= mem[ram_addrb];
    if (ram_ena && ram_wea) mem[ram_addra] <= ram_dina;
  end

  // Scoreboard
  logic [DW+TW-1:0] exp_q[$];
  logic [DW+TW-1:0] mon_e;
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (aresetn && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_rsp: got tag %0h data %0h expected no response", rsp_tag, rsp_data);
      end else begin
        mon_e = exp_q.pop_front();
        check("rsp_data", {16'h0, rsp_data}, {16'h0, mon_e[DW+TW-1:TW]});
        check("rsp_tag", {24'h0, rsp_tag}, {24'h0, mon_e[TW-1:0]});
      end
    end
  end

  // Driver tasks (called at posedge+1, return at posedge+1)
  task automatic drive(input logic dw, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic dl, input logic [AW-1:0] la, input logic [TW-1:0] tg,
                       input logic [DW-1:0] ex, input string nm);
    int n;
    cfg_wr_valid = dw; cfg_wr_addr = wa; cfg_wr_data = wd;
    lkup_valid = dl; lkup_addr = la; lkup_tag = tg;
    n = 0;
    @(negedge clk);
    while (dl && !lkup_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (dw) check({nm, "_wr_ready"}, {31'h0, cfg_wr_ready}, 32'd1);
    if (dl) begin
      check({nm, "_lk_ready"}, {31'h0, lkup_ready}, 32'd1);
      if (lkup_ready) exp_q.push_back({ex, tg});
    end
    @(posedge clk); #1;
    cfg_wr_valid = 1'b0;
    lkup_valid = 1'b0;
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check(nm, exp_q.size(), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic wait_init(input string nm);
    int n;
    n = 0;
    @(negedge clk);
    while (!init_done && n < 60) begin
      @(negedge clk);
      n++;
    end
    check(nm, {31'h0, init_done}, 32'd1);
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic          dw;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic          dl;
    logic [AW-1:0] la;
    logic [TW-1:0] tg;
    logic [DW-1:0] ex;
  } vec_t;
  vec_t vecs [11];

  initial begin
    int n, cnt;
    for (int i = 0; i < 32; i++) mem[i] = 16'hDEAD ^ 16'(i);
    ram_doutb = '0;
    vecs[0]  = '{1'b1, 5'd5,  16'hBEEF, 1'b0, 5'd0,  8'h00, 16'h0000};
    vecs[1]  = '{1'b0, 5'd0,  16'h0000, 1'b1, 5'd5,  8'h3C, 16'hBEEF};
    vecs[2]  = '{1'b1, 5'd9,  16'h1234, 1'b1, 5'd9,  8'h11, 16'h1234};
    vecs[3]  = '{1'b0, 5'd0,  16'h0000, 1'b1, 5'd9,  8'h12, 16'h1234};
    vecs[4]  = '{1'b0, 5'd0,  16'h0000, 1'b1, 5'd7,  8'h13, 16'h0000};
    vecs[5]  = '{1'b1, 5'd0,  16'hA5A5, 1'b1, 5'd31, 8'h14, 16'h0000};
    vecs[6]  = '{1'b0, 5'd0,  16'h0000, 1'b1, 5'd0,  8'h15, 16'hA5A5};
    vecs[7]  = '{1'b1, 5'd31, 16'hFFFF, 1'b1, 5'd31, 8'h16, 16'hFFFF};
    vecs[8]  = '{1'b0, 5'd0,  16'h0000, 1'b1, 5'd31, 8'h17, 16'hFFFF};
    vecs[9]  = '{1'b1, 5'd9,  16'h5678, 1'b1, 5'd5,  8'h18, 16'hBEEF};
    vecs[10] = '{1'b0, 5'd0,  16'h0000, 1'b1, 5'd9,  8'h19, 16'h5678};

    // Reset state
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_init_done", {31'h0, init_done}, 32'd0);
    check("rst_wr_ready", {31'h0, cfg_wr_ready}, 32'd0);
    check("rst_lk_ready", {31'h0, lkup_ready}, 32'd0);
    check("rst_rsp_valid", {31'h0, rsp_valid}, 32'd0);
    check("rst_ram_ena", {31'h0, ram_ena}, 32'd0);
    check("rst_ram_wea", {31'h0, ram_wea}, 32'd0);
    check("rst_ram_enb", {31'h0, ram_enb}, 32'd0);
    check("rst_state", {31'h0, dbg_state}, 32'd0);

    // Initial clear: 32 writes of zero at 0..31, then init_done
    aresetn = 1'b1;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      check("init_wea", {31'h0, ram_wea}, 32'd1);
      check("init_addr", {27'h0, ram_addra}, i);
      check("init_dina", {16'h0, ram_dina}, 32'd0);
      check("init_lk_ready", {31'h0, lkup_ready}, 32'd0);
    end
    @(negedge clk);
    check("init_done_rise", {31'h0, init_done}, 32'd1);
    check("init_wea_off", {31'h0, ram_wea}, 32'd0);
    check("run_state", {31'h0, dbg_state}, 32'd1);
    @(posedge clk); #1;

    // Table-driven writes/lookups
    foreach (vecs[i])
      drive(vecs[i].dw, vecs[i].wa, vecs[i].wd, vecs[i].dl, vecs[i].la, vecs[i].tg,
            vecs[i].ex, $sformatf("vec%0d", i));
    drain("vec_drain");
`ifdef PAGE_TBL_CTRL_STATS_EN
    check("stat_lkup", stat_lkup_cnt, 32'd10);
    check("stat_fwd", {16'h0, stat_fwd_cnt}, 32'd2);
`endif

    // Lookup latency: response valid two cycles after acceptance
    lkup_valid = 1'b1; lkup_addr = 5'd5; lkup_tag = 8'h3C;
    @(negedge clk);
    check("lat_ready", {31'h0, lkup_ready}, 32'd1);
    check("lat_enb", {31'h0, ram_enb}, 32'd1);
    check("lat_addrb", {27'h0, ram_addrb}, 32'd5);
    if (lkup_ready) exp_q.push_back({16'hBEEF, 8'h3C});
    @(posedge clk); #1;
    lkup_valid = 1'b0;
    @(negedge clk);
    check("lat_t1_valid", {31'h0, rsp_valid}, 32'd0);
    @(negedge clk);
    check("lat_t2_valid", {31'h0, rsp_valid}, 32'd1);
    @(posedge clk); #1;
    drain("lat_drain");

    // Backpressure: only two lookups held, third waits for a pop
    rsp_ready = 1'b0;
    lkup_valid = 1'b1; lkup_addr = 5'd5; lkup_tag = 8'h01;
    @(negedge clk);
    check("bp_ready1", {31'h0, lkup_ready}, 32'd1);
    if (lkup_ready) exp_q.push_back({16'hBEEF, 8'h01});
    @(posedge clk); #1;
    lkup_addr = 5'd9; lkup_tag = 8'h02;
    @(negedge clk);
    check("bp_ready2", {31'h0, lkup_ready}, 32'd1);
    if (lkup_ready) exp_q.push_back({16'h5678, 8'h02});
    @(posedge clk); #1;
    lkup_addr = 5'd0; lkup_tag = 8'h03;
    @(negedge clk);
    check("bp_full_ready", {31'h0, lkup_ready}, 32'd0);
    repeat (3) @(negedge clk);
    check("bp_hold_ready", {31'h0, lkup_ready}, 32'd0);
    check("bp_hold_valid", {31'h0, rsp_valid}, 32'd1);
    check("bp_hold_tag", {24'h0, rsp_tag}, 32'h01);
    check("bp_hold_data", {16'h0, rsp_data}, 32'hBEEF);
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    n = 0;
    @(negedge clk);
    while (!lkup_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("bp_resume", {31'h0, lkup_ready}, 32'd1);
    if (lkup_ready) exp_q.push_back({16'hA5A5, 8'h03});
    @(posedge clk); #1;
    lkup_valid = 1'b0;
    drain("bp_drain");

    // Clear request with two buffered responses
    rsp_ready = 1'b0;
    drive(1'b0, 5'd0, 16'h0, 1'b1, 5'd5, 8'h21, 16'hBEEF, "clr_lk1");
    drive(1'b0, 5'd0, 16'h0, 1'b1, 5'd31, 8'h22, 16'hFFFF, "clr_lk2");
    clr_req = 1'b1;
    @(posedge clk); #1;
    clr_req = 1'b0;
    @(negedge clk);
    check("clr_wr_ready", {31'h0, cfg_wr_ready}, 32'd0);
    check("clr_lk_ready", {31'h0, lkup_ready}, 32'd0);
    check("clr_init_hold", {31'h0, init_done}, 32'd1);
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    n = 0;
    @(negedge clk);
    while (!ram_wea && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("clr_start", {31'h0, ram_wea}, 32'd1);
    check("clr_rsp_done", exp_q.size(), 32'd0);
    check("clr_init_low", {31'h0, init_done}, 32'd0);
    cnt = 0;
    while (ram_wea && cnt < 40) begin
      check("clr_addr", {27'h0, ram_addra}, cnt);
      cnt++;
      @(negedge clk);
    end
    check("clr_len", cnt, 32'd32);
    check("clr_init_done", {31'h0, init_done}, 32'd1);
    @(posedge clk); #1;
    drive(1'b0, 5'd0, 16'h0, 1'b1, 5'd5, 8'h23, 16'h0000, "clr_rd5");
    drain("clr_drain");
`ifdef PAGE_TBL_CTRL_STATS_EN
    check("stat_lkup_clr", stat_lkup_cnt, 32'd1);
    check("stat_fwd_clr", {16'h0, stat_fwd_cnt}, 32'd0);
`endif

    // Reset while a lookup is in flight: no response, clear restarts at 0
    lkup_valid = 1'b1; lkup_addr = 5'd5; lkup_tag = 8'h44;
    @(negedge clk);
    check("rstf_ready", {31'h0, lkup_ready}, 32'd1);
    @(posedge clk); #2;
    lkup_valid = 1'b0;
    aresetn = 1'b0;
    @(negedge clk);
    check("rstf_valid0", {31'h0, rsp_valid}, 32'd0);
    check("rstf_enb", {31'h0, ram_enb}, 32'd0);
    @(negedge clk);
    check("rstf_valid1", {31'h0, rsp_valid}, 32'd0);
    @(posedge clk); #1;
    aresetn = 1'b1;
    @(negedge clk);
    check("rstf_wea", {31'h0, ram_wea}, 32'd1);
    check("rstf_addr0", {27'h0, ram_addra}, 32'd0);
    check("rstf_valid2", {31'h0, rsp_valid}, 32'd0);
    @(posedge clk); #1;
    wait_init("rstf_init");
    drive(1'b0, 5'd0, 16'h0, 1'b1, 5'd9, 8'h45, 16'h0000, "rstf_rd9");
    drain("final_drain");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
